// File: rtl/barrel_rotate_amount_finder_16bit.sv
// ---------------------------------------------------------------------------
// barrel_rotate_amount_finder_16bit
//
// Purpose:
//   Recovers the rotation applied by a 16-bit rotator. Given the original
//   word a and the rotated word y, it finds the smallest right-rotation
//   amount k (0..15) for which ror(a, k) == y. It also reports the equivalent
//   left-rotation amount (16 - k) mod 16. One candidate amount is tried per
//   clock, under a start/ready/done handshake.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   reset      in   1   synchronous, active-high reset
//   start      in   1   request a search, accepted only while ready=1
//   a          in  16   original word, captured when start is accepted
//   y          in  16   rotated word, captured when start is accepted
//   ready      out  1   high while idle, so a new start can be accepted
//   done       out  1   one-cycle pulse when a search finishes
//   found      out  1   last search matched; held until the next accepted start
//   amt_right  out  4   smallest k with ror(a,k)==y, 0 when found=0
//   amt_left   out  4   (16 - amt_right) mod 16, 0 when found=0
// ---------------------------------------------------------------------------
module barrel_rotate_amount_finder_16bit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] y,
  output logic        ready,
  output logic        done,
  output logic        found,
  output logic [3:0]  amt_right,
  output logic [3:0]  amt_left
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SEARCH = 1'b1
  } state_t;

  state_t      state;
  logic [15:0] work;
  logic [15:0] target;
  logic [3:0]  cnt;

  logic        cand_match;
  logic        last_cand;

  // work always holds ror(captured a, cnt), so a match on the current
  // candidate means cnt is the rotation amount being tested.
  assign cand_match = (work == target);
  assign last_cand  = (cnt == 4'd15);

  // Single state machine with registered outputs. done defaults low every
  // cycle, so any assignment of 1 below yields a one-cycle pulse. Candidates
  // are tried in ascending order, so the first hit is the smallest k, even
  // for periodic words such as 0xAAAA that match at several amounts.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      work      <= 16'd0;
      target    <= 16'd0;
      cnt       <= 4'd0;
      ready     <= 1'b1;
      done      <= 1'b0;
      found     <= 1'b0;
      amt_right <= 4'd0;
      amt_left  <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            work      <= a;
            target    <= y;
            cnt       <= 4'd0;
            found     <= 1'b0;
            amt_right <= 4'd0;
            amt_left  <= 4'd0;
            ready     <= 1'b0;
            state     <= SEARCH;
          end
        end

        SEARCH: begin
          if (cand_match) begin
            found     <= 1'b1;
            amt_right <= cnt;
            // 4-bit wrap makes k=0 report a left amount of 0 rather than 16
            amt_left  <= 4'd0 - cnt;
            done      <= 1'b1;
            ready     <= 1'b1;
            state     <= IDLE;
          end else if (last_cand) begin
            found     <= 1'b0;
            amt_right <= 4'd0;
            amt_left  <= 4'd0;
            done      <= 1'b1;
            ready     <= 1'b1;
            state     <= IDLE;
          end else begin
            work <= {work[0], work[15:1]};
            cnt  <= cnt + 4'd1;
          end
        end

        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
